stream_unpacker: RTL and testbench

//  AXI4-Stream video sink: the receive-side inverse of the pixel packer. Accepts 32-bit words carrying a packed
//  24-bit RGB byte stream (4 pixels per 3 words) with SOF on tuser and EOL on tlast, and re-emits one
//  {r,g,b} pixel per cycle with screen coordinates. Also checks frame geometry.

---
 rtl/video_pkg.sv | 17 +
 rtl/rgb_byte_buffer.sv | 62 ++++++
 rtl/stream_unpacker.sv | 155 +++++++++++++++
 tb/tb_stream_unpacker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions for the pixel generator, packer and unpacker.
//   SCREEN_WIDTH / SCREEN_HEIGHT : default frame geometry
//   COLOR_WIDTH                  : bits per colour channel (fixed at 8)
//   rgb_t                        : one {r,g,b} pixel
package video_pkg;

    localparam int unsigned SCREEN_WIDTH  = 640;
    localparam int unsigned SCREEN_HEIGHT = 480;
    localparam int unsigned COLOR_WIDTH   = 8;

    typedef struct packed {
        logic [COLOR_WIDTH-1:0] r;
        logic [COLOR_WIDTH-1:0] g;
        logic [COLOR_WIDTH-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_byte_buffer.sv
// 7-byte append/consume buffer feeding the unpacker.
//   clk, rst_n : clock, asynchronous active-low reset
//   consume    : drop the oldest 3 bytes (one pixel)
//   flush      : discard all held bytes before any append
//   append     : add the 4 bytes of data after consume/flush
//   data       : appended bytes, data[7:0] oldest
//   cnt        : bytes held (0..7)
//   pixel      : {r,g,b} taken from bytes 2/1/0
// The caller guarantees that an append never lands beyond byte 6.
module rgb_byte_buffer
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        consume,
    input  logic        flush,
    input  logic        append,
    input  logic [31:0] data,
    output logic [2:0]  cnt,
    output rgb_t        pixel
);

    logic [55:0] bytes_q;
    logic [55:0] kept;
    logic [55:0] bytes_d;
    logic [2:0]  base;
    logic [2:0]  cnt_d;

    // Bytes above cnt are always zero, so an append can simply be OR-ed in.
    always_comb begin
        kept  = bytes_q;
        base  = cnt;
        if (flush) begin
            kept = '0;
            base = '0;
        end else if (consume) begin
            kept = bytes_q >> 24;
            base = cnt - 3'd3;
        end
        bytes_d = kept;
        cnt_d   = base;
        if (append) begin
            bytes_d = kept | ({24'd0, data} << {base, 3'b000});
            cnt_d   = base + 3'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_q <= '0;
            cnt     <= '0;
        end else begin
            bytes_q <= bytes_d;
            cnt     <= cnt_d;
        end
    end

    assign pixel.r = bytes_q[23:16];
    assign pixel.g = bytes_q[15:8];
    assign pixel.b = bytes_q[7:0];

endmodule

// File: rtl/stream_unpacker.sv
// AXI4-Stream video sink: unpacks 32-bit words carrying a packed 24-bit RGB
// byte stream into one pixel per cycle with screen coordinates, and checks
// frame geometry.
//   aclk, aresetn        : stream clock, asynchronous active-low reset
//   in_stream_*          : packed input stream (tuser = SOF, tlast = EOL)
//   r, g, b              : pixel channels
//   pix_x, pix_y         : pixel coordinates
//   pix_sof, pix_eol     : pixel is (0,0) / last of its line
//   pix_valid, pix_ready : pixel handshake
//   err_clear            : clears the sticky error flags
//   sof_err, line_err, keep_err : sticky error flags
//   frame_count          : completed frames, wraps
module stream_unpacker
    import video_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = video_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = video_pkg::SCREEN_HEIGHT,
    parameter int unsigned COLOR_WIDTH   = video_pkg::COLOR_WIDTH
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [31:0]            in_stream_tdata,
    input  logic [3:0]             in_stream_tkeep,
    input  logic                   in_stream_tlast,
    input  logic                   in_stream_tuser,
    input  logic                   in_stream_tvalid,
    output logic                   in_stream_tready,
    output logic [COLOR_WIDTH-1:0] r,
    output logic [COLOR_WIDTH-1:0] g,
    output logic [COLOR_WIDTH-1:0] b,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    input  logic                   err_clear,
    output logic                   sof_err,
    output logic                   line_err,
    output logic                   keep_err,
    output logic [15:0]            frame_count
);

    localparam int unsigned WPL = SCREEN_WIDTH * 3 / 4;
    localparam int unsigned WCW = (WPL > 1) ? $clog2(WPL) : 1;

    localparam logic [WCW-1:0] WC_LAST = WCW'(WPL - 1);
    localparam logic [9:0]     X_LAST  = 10'(SCREEN_WIDTH - 1);
    localparam logic [8:0]     Y_LAST  = 9'(SCREEN_HEIGHT - 1);

    // Stream lock: words are discarded until the first tuser after reset.
    localparam logic [0:0] SYNC_WAIT = 1'b0;
    localparam logic [0:0] SYNC_LOCK = 1'b1;

    logic [0:0]     state;
    logic [2:0]     cnt;
    rgb_t           pixel;
    logic [9:0]     x;
    logic [8:0]     y;
    logic [WCW-1:0] wc;
    logic [WCW-1:0] wc_pos;

    logic word_hs;
    logic sof_word;
    logic use_word;
    logic pix_hs;
    logic at_last;
    logic line_bad;
    logic sof_bad;
    logic keep_bad;

    assign pix_valid = (cnt >= 3'd3);
    assign pix_hs    = pix_valid & pix_ready;

    // A SOF word waits until no whole pixel is left, so any residue is < 3 bytes.
    always_comb begin
        if (in_stream_tuser && cnt >= 3'd3)
            in_stream_tready = 1'b0;
        else
            in_stream_tready = (cnt <= 3'd3) || (cnt <= 3'd6 && pix_ready);
    end

    assign word_hs  = in_stream_tvalid & in_stream_tready;
    assign sof_word = word_hs & in_stream_tuser;
    assign use_word = word_hs & (in_stream_tuser | (state == SYNC_LOCK));

    // Position of the current word within its line; a SOF word starts at 0.
    assign wc_pos   = in_stream_tuser ? '0 : wc;
    assign at_last  = (wc_pos == WC_LAST);
    assign line_bad = use_word & (in_stream_tlast ^ at_last);
    assign sof_bad  = sof_word & (state == SYNC_LOCK) &
                      ((cnt != 3'd0) || (wc != '0) || (x != '0) || (y != '0));
    assign keep_bad = word_hs & (in_stream_tkeep != 4'hF);

    rgb_byte_buffer u_buffer (
        .clk     (aclk),
        .rst_n   (aresetn),
        .consume (pix_hs),
        .flush   (sof_word),
        .append  (use_word),
        .data    (in_stream_tdata),
        .cnt     (cnt),
        .pixel   (pixel)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= SYNC_WAIT;
            x           <= '0;
            y           <= '0;
            wc          <= '0;
            frame_count <= '0;
            sof_err     <= 1'b0;
            line_err    <= 1'b0;
            keep_err    <= 1'b0;
        end else begin
            if (sof_word)
                state <= SYNC_LOCK;

            if (use_word)
                wc <= (in_stream_tlast || at_last) ? '0 : wc_pos + 1'b1;

            if (sof_word) begin
                x <= '0;
                y <= '0;
            end else if (pix_hs) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y           <= '0;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        y <= y + 9'd1;
                    end
                end else begin
                    x <= x + 10'd1;
                end
            end

            // A set event in the same cycle as err_clear takes priority.
            sof_err  <= sof_bad  | (sof_err  & ~err_clear);
            line_err <= line_bad | (line_err & ~err_clear);
            keep_err <= keep_bad | (keep_err & ~err_clear);
        end
    end

    assign r       = pixel.r;
    assign g       = pixel.g;
    assign b       = pixel.b;
    assign pix_x   = x;
    assign pix_y   = y;
    assign pix_sof = pix_valid & (x == '0) & (y == '0);
    assign pix_eol = pix_valid & (x == X_LAST);

endmodule

// File: tb/tb_stream_unpacker.sv
module tb_stream_unpacker;

    localparam int W = 8;
    localparam int H = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] in_stream_tdata = '0;
    logic [3:0]  in_stream_tkeep = 4'hF;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  r, g, b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        err_clear = 1'b0;
    logic        sof_err, line_err, keep_err;
    logic [15:0] frame_count;

    stream_unpacker #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .COLOR_WIDTH   (8)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_sof          (pix_sof),
        .pix_eol          (pix_eol),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .err_clear        (err_clear),
        .sof_err          (sof_err),
        .line_err         (line_err),
        .keep_err         (keep_err),
        .frame_count      (frame_count)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard / reference model
    logic [7:0]  bq[$];
    logic [44:0] expq[$];
    int cnt_m = 0;
    bit synced = 0;
    int mx = 0, my = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0, hs_count = 0;
    bit bp = 0;
    bit pr_hold = 1;

    initial begin : monitor
        logic [44:0] e;
        logic        tr_e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                bq.delete();
                expq.delete();
                cnt_m  = 0;
                synced = 0;
                mx = 0;
                my = 0;
            end else begin
                cyc++;
                if (in_stream_tuser && cnt_m >= 3)
                    tr_e = 1'b0;
                else
                    tr_e = (cnt_m <= 3) || (cnt_m <= 6 && pix_ready);
                check("tready", in_stream_tready, tr_e);
                check("pix_valid", pix_valid, cnt_m >= 3);
                if (pix_valid && pix_ready) begin
                    check("sb_nonempty", expq.size() != 0, 1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        check("pixel", {r, g, b, pix_x, pix_y, pix_sof, pix_eol}, e);
                    end
                    if (hs_count == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    hs_count++;
                    cnt_m -= 3;
                end
                if (in_stream_tvalid && in_stream_tready) begin
                    if (in_stream_tuser) begin
                        bq.delete();
                        mx = 0;
                        my = 0;
                        synced = 1;
                        cnt_m = 0;
                    end
                    if (synced) begin
                        cnt_m += 4;
                        for (int k = 0; k < 4; k++) bq.push_back(in_stream_tdata[8*k +: 8]);
                        while (bq.size() >= 3) begin
                            expq.push_back({bq[2], bq[1], bq[0], 10'(mx), 9'(my),
                                            1'(mx == 0 && my == 0), 1'(mx == W-1)});
                            void'(bq.pop_front());
                            void'(bq.pop_front());
                            void'(bq.pop_front());
                            if (mx == W-1) begin
                                mx = 0;
                                my = (my == H-1) ? 0 : my + 1;
                            end else begin
                                mx++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge aclk);
            #1;
            pix_ready = bp ? 1'($urandom_range(0, 1)) : pr_hold;
        end
    end

    task automatic send_word(input logic [31:0] d, input bit user, input bit last,
                             input logic [3:0] keep = 4'hF);
        int n;
        bit got;
        in_stream_tdata  = d;
        in_stream_tuser  = user;
        in_stream_tlast  = last;
        in_stream_tkeep  = keep;
        in_stream_tvalid = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            got = in_stream_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        check("word_accept", got, 1);
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
        in_stream_tkeep  = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || cnt_m >= 3) && n < 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("drain", expq.size(), 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic send_frame(input int seed, input bit gaps);
        for (int i = 0; i < 12; i++) begin
            send_word(seed + 32'h04040404 * i + 32'h03020100, i == 0, (i == 5) || (i == 11));
            if (gaps) idle($urandom_range(0, 1));
        end
    endtask

    task automatic send_basic();
        send_word(32'h44332211, 1, 0);
        send_word(32'h88776655, 0, 0);
        send_word(32'hCCBBAA99, 0, 0);
    endtask

    initial begin : stimulus
        #12;
        check("rst_tready", in_stream_tready, 1);
        check("rst_valid", pix_valid, 0);
        check("rst_xy", {pix_x, pix_y}, 0);
        check("rst_frames", frame_count, 0);
        check("rst_flags", {sof_err, line_err, keep_err}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Words before the first SOF are dropped without flagging sof_err.
        send_word(32'hDEADBEEF, 0, 0);
        send_word(32'h01020304, 0, 1);
        idle(3);
        check("presync_valid", pix_valid, 0);
        check("presync_flags", {sof_err, line_err, keep_err}, 0);

        // Full rate: one pixel per cycle across a whole frame.
        hs_count = 0;
        send_frame(32'h10101010, 0);
        wait_drain();
        check("fr_pixels", hs_count, 16);
        check("fr_span", last_cyc - first_cyc, 15);
        check("fr_frames", frame_count, 1);
        check("fr_flags", {sof_err, line_err, keep_err}, 0);

        // Backpressure with random pix_ready and tvalid gaps.
        bp = 1;
        hs_count = 0;
        send_frame(32'($urandom), 1);
        wait_drain();
        bp = 0;
        check("bp_pixels", hs_count, 16);
        check("bp_frames", frame_count, 2);
        check("bp_flags", {sof_err, line_err, keep_err}, 0);

        // Basic sequence at a clean frame start.
        send_basic();
        wait_drain();
        check("basic_flags", {sof_err, line_err, keep_err}, 0);

        // Early tlast on the 4th word of a line.
        send_word(32'h0A0B0C0D, 1, 0);
        send_word(32'h1A1B1C1D, 0, 0);
        send_word(32'h2A2B2C2D, 0, 0);
        send_word(32'h3A3B3C3D, 0, 1);
        wait_drain();
        check("early_line_err", line_err, 1);
        pulse_clear();
        check("cleared_flags", {sof_err, line_err, keep_err}, 0);

        // Misplaced SOF with one residual byte.
        send_word(32'h55667788, 1, 0);
        wait_drain();
        pulse_clear();
        check("pre_misplaced_flags", {sof_err, line_err, keep_err}, 0);
        send_word(32'h99AABBCC, 1, 0);
        check("misplaced_sof_err", sof_err, 1);
        send_word(32'hE0E1E2E3, 0, 0, 4'h7);
        check("keep_err", keep_err, 1);
        wait_drain();

        // Asynchronous reset mid-line with a pixel held.
        pr_hold = 0;
        send_word(32'h12345678, 1, 0);
        idle(2);
        check("held_valid", pix_valid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_valid", pix_valid, 0);
        check("arst_rgb", {r, g, b}, 0);
        check("arst_sof", pix_sof, 0);
        check("arst_tready", in_stream_tready, 1);
        check("arst_flags", {sof_err, line_err, keep_err}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        pr_hold = 1;
        send_word(32'hFEEDFACE, 0, 0);
        send_word(32'hCAFEF00D, 0, 0);
        idle(3);
        check("post_rst_valid", pix_valid, 0);
        send_basic();
        wait_drain();
        check("post_rst_flags", {sof_err, line_err, keep_err}, 0);
        check("post_rst_frames", frame_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        check("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
